// File: rtl/user_mux_wr_q_pkg.sv
// rtl/user_mux_wr_q_pkg.sv - shared widths, routing command layout and helpers for the write mux
package user_mux_wr_q_pkg;

   localparam int AXI_DATA_BITS = 512;
   localparam int N_STRM_AXI    = 4;
   localparam int DEST_BITS     = 4;
   localparam int LEN_BITS      = 28;
   localparam int PID_BITS      = 6;

   // dest occupies the low bits of the command word, len sits directly above it
   typedef struct packed {
      logic [LEN_BITS-1:0]  len;
      logic [DEST_BITS-1:0] dest;
   } mux_wr_cmd_t;

   function automatic int clog2s(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/user_mux_wr_q_if.sv
// rtl/user_mux_wr_q_if.sv - command (meta) and multi-lane AXI4SR stream interfaces for the write mux
interface meta_if #(parameter int W = 32);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport m (output valid, output data, input ready);
   modport s (input valid, input data, output ready);
endinterface

interface axis_if
   import user_mux_wr_q_pkg::*;
#(parameter int DATA_BITS = 512, parameter int N = 1);
   logic [N-1:0]                  tvalid;
   logic [N-1:0]                  tready;
   logic [N-1:0][DATA_BITS-1:0]   tdata;
   logic [N-1:0][DATA_BITS/8-1:0] tkeep;
   logic [N-1:0][PID_BITS-1:0]    tid;
   logic [N-1:0]                  tlast;

   modport m (output tvalid, output tdata, output tkeep, output tid, output tlast, input tready);
   modport s (input tvalid, input tdata, input tkeep, input tid, input tlast, output tready);
endinterface

// File: rtl/user_mux_wr_q_queue.sv
// rtl/user_mux_wr_q_queue.sv - queue_meta: DEPTH-entry synchronous command FIFO with full/empty/count
module queue_meta
   import user_mux_wr_q_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    push_i,
   input  logic [W-1:0]            din_i,
   input  logic                    pop_i,
   output logic [W-1:0]            dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [clog2s(DEPTH):0]  count_o
);
   localparam int AW = clog2s(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q + AW'(push_i);
      rd_d  = rd_q + AW'(pop_i);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/user_mux_wr_q.sv
// rtl/user_mux_wr_q.sv - command-queued N_ID:1 AXI4SR write mux, zero-bubble switching
// Optional: USER_MUX_WR_LAST_CHECK_EN regenerates tlast from the beat count and flags source mismatches.
module user_mux_wr_q
   import user_mux_wr_q_pkg::*;
#(
   parameter int DATA_BITS = AXI_DATA_BITS,
   parameter int N_ID      = N_STRM_AXI,
   parameter int CMD_DEPTH = 8
) (
   input  logic                       aclk,
   input  logic                       areset,
   meta_if.s                          mux,
   axis_if.s                          s_axis,
   axis_if.m                          m_axis,
   output logic [$clog2(CMD_DEPTH):0] cmd_used,
   output logic                       err_dest,
   output logic                       err_last
);
   localparam int BEAT_LOG_BITS = $clog2(DATA_BITS / 8);
   localparam int BLEN_BITS     = LEN_BITS - BEAT_LOG_BITS + 1;

   typedef enum logic {ST_IDLE, ST_MUX} state_t;

   state_t                 state_q, state_d;
   logic [DEST_BITS-1:0]   dest_q, dest_d;
   logic [BLEN_BITS-1:0]   cnt_q, cnt_d;
   logic                   err_dest_q, err_dest_d;

   mux_wr_cmd_t            head;
   logic                   q_full, q_empty, q_pop, take;
   logic                   head_bad, head_ok;
   logic [BLEN_BITS-1:0]   head_cnt;
   logic                   active, hs;
   logic                   sel_valid, sel_last;
   logic [DATA_BITS-1:0]   sel_data;
   logic [DATA_BITS/8-1:0] sel_keep;
   logic [PID_BITS-1:0]    sel_id;
   logic [N_ID-1:0]        src_ready;

   assign mux.ready = !q_full && !areset;

   queue_meta #(.W($bits(mux_wr_cmd_t)), .DEPTH(CMD_DEPTH)) u_queue (
      .aclk    (aclk),
      .areset  (areset),
      .push_i  (mux.valid && mux.ready),
      .din_i   (mux.data),
      .pop_i   (q_pop),
      .dout_o  (head),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (cmd_used)
   );

   assign head_bad = !(32'(head.dest) < 32'(N_ID));
   assign head_ok  = !head_bad && (head.len != '0);
   assign head_cnt = BLEN_BITS'((head.len - LEN_BITS'(1)) >> BEAT_LOG_BITS);

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_id    = '0;
      sel_last  = 1'b0;
      src_ready = '0;
      for (int i = 0; i < N_ID; i++) begin
         if (dest_q == DEST_BITS'(i)) begin
            sel_valid    = s_axis.tvalid[i];
            sel_data     = s_axis.tdata[i];
            sel_keep     = s_axis.tkeep[i];
            sel_id       = s_axis.tid[i];
            sel_last     = s_axis.tlast[i];
            src_ready[i] = active && m_axis.tready[0];
         end
      end
   end

   // reset forces the handshake lines low without waiting for the registers
   assign active          = (state_q == ST_MUX) && !areset;
   assign hs              = active && sel_valid && m_axis.tready[0];
   assign s_axis.tready   = src_ready;
   assign m_axis.tvalid   = active && sel_valid;
   assign m_axis.tdata    = sel_data;
   assign m_axis.tkeep    = sel_keep;
   assign m_axis.tid      = sel_id;

   always_comb begin
      state_d    = state_q;
      dest_d     = dest_q;
      cnt_d      = cnt_q;
      err_dest_d = err_dest_q;
      take       = 1'b0;
      unique case (state_q)
         ST_IDLE: take = !q_empty;
         ST_MUX: begin
            if (hs) begin
               if (cnt_q == '0) begin
                  take    = !q_empty;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - BLEN_BITS'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // zero-length and out-of-range commands are consumed here and never enter ST_MUX
      if (take) begin
         dest_d  = head.dest;
         cnt_d   = head_cnt;
         state_d = head_ok ? ST_MUX : ST_IDLE;
         if (head_bad) err_dest_d = 1'b1;
      end
      q_pop = take;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         dest_q     <= '0;
         cnt_q      <= '0;
         err_dest_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dest_q     <= dest_d;
         cnt_q      <= cnt_d;
         err_dest_q <= err_dest_d;
      end
   end

   assign err_dest = err_dest_q;

`ifdef USER_MUX_WR_LAST_CHECK_EN
   logic err_last_q, err_last_d;

   always_comb begin
      err_last_d = err_last_q;
      if (hs && (sel_last != (cnt_q == '0))) err_last_d = 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (areset) err_last_q <= 1'b0;
      else        err_last_q <= err_last_d;
   end

   assign m_axis.tlast = (cnt_q == '0);
   assign err_last     = err_last_q;
`else
   assign m_axis.tlast = sel_last;
   assign err_last     = 1'b0;
`endif

endmodule

// File: tb/tb_user_mux_wr_q.sv
// tb/tb_user_mux_wr_q.sv - randomized scoreboard bench for user_mux_wr_q
`timescale 1ns/1ps
module tb_user_mux_wr_q;
   import user_mux_wr_q_pkg::*;

   localparam int DB = 512;
   localparam int NI = 4;
   localparam int CD = 4;
   localparam int BB = DB / 8;
`ifdef USER_MUX_WR_LAST_CHECK_EN
   localparam bit LAST_CHK = 1'b1;
`else
   localparam bit LAST_CHK = 1'b0;
`endif

   logic                 aclk = 1'b0;
   logic                 areset = 1'b1;
   logic [$clog2(CD):0]  cmd_used;
   logic                 err_dest, err_last;
   int                   checks = 0;
   int                   errors = 0;

   meta_if #(.W($bits(mux_wr_cmd_t))) mux ();
   axis_if #(.DATA_BITS(DB), .N(NI))  s_axis ();
   axis_if #(.DATA_BITS(DB), .N(1))   m_axis ();

   user_mux_wr_q #(.DATA_BITS(DB), .N_ID(NI), .CMD_DEPTH(CD)) dut (
      .aclk     (aclk),
      .areset   (areset),
      .mux      (mux),
      .s_axis   (s_axis),
      .m_axis   (m_axis),
      .cmd_used (cmd_used),
      .err_dest (err_dest),
      .err_last (err_last)
   );

   always #5 aclk = ~aclk;

   typedef struct { int dest; int left; } xfer_t;
   xfer_t exp_q[$];
   int    src_cnt[NI];
   int    last_mark = -1;
   int    last_base = 0;
   bit    err_dest_exp = 0;
   bit    err_last_exp = 0;
   bit    sends_done = 1;
   int    cyc_first, cyc_last, cyc_n;

   function automatic logic [DB-1:0] beat_data(input int i, input int k);
      logic [DB-1:0] d;
      for (int w = 0; w < DB / 32; w++)
         d[w*32 +: 32] = 32'(i << 24) ^ (32'(k) * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B);
      return d;
   endfunction

   function automatic logic [BB-1:0] keep_of(input int i, input int k);
      return {2{32'(k) ^ 32'(i << 16)}};
   endfunction

   function automatic logic [PID_BITS-1:0] id_of(input int i, input int k);
      return PID_BITS'(i * 7 + k);
   endfunction

   function automatic logic src_last(input int i, input int k);
      if (last_mark >= 0) return (k - last_base) == last_mark;
      return ((k * 3 + i) % 5) == 0;
   endfunction

   task automatic drive_sources(input int vld_pct);
      for (int i = 0; i < NI; i++) begin
         s_axis.tvalid[i] = ($urandom_range(99) < vld_pct);
         s_axis.tdata[i]  = beat_data(i, src_cnt[i]);
         s_axis.tkeep[i]  = keep_of(i, src_cnt[i]);
         s_axis.tid[i]    = id_of(i, src_cnt[i]);
         s_axis.tlast[i]  = src_last(i, src_cnt[i]);
      end
   endtask

   task automatic send_cmd(input int dest, input int len);
      int wait_n = 0;
      @(negedge aclk);
      mux.valid = 1'b1;
      mux.data  = {LEN_BITS'(len), DEST_BITS'(dest)};
      #1;
      while (mux.ready !== 1'b1 && wait_n < 200) begin
         @(negedge aclk);
         #1;
         wait_n++;
      end
      checks++;
      if (mux.ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready: ready=%b required 1 within 200 cycles", mux.ready);
      end else begin
         @(posedge aclk);
         if (dest >= NI) err_dest_exp = 1'b1;
         else if (len > 0) exp_q.push_back('{dest, (len + BB - 1) / BB});
      end
      #1 mux.valid = 1'b0;
   endtask

   task automatic run_traffic(input string name, input int rdy_pct, input int vld_pct,
                              input int budget, input int tail);
      int            n = 0;
      int            idle = 0;
      int            d;
      logic          exp_last;
      logic [NI-1:0] allowed;
      cyc_first = -1; cyc_last = -1; cyc_n = 0;
      while (idle < tail && n < budget) begin
         @(negedge aclk);
         m_axis.tready = ($urandom_range(99) < rdy_pct);
         drive_sources(vld_pct);
         #1;
         d = (exp_q.size() > 0) ? exp_q[0].dest : -1;
         allowed = (d >= 0) ? (NI'(1) << d) : '0;
         checks++;
         if ((s_axis.tready & ~allowed) !== '0 || (d < 0 && m_axis.tvalid !== 1'b0)) begin
            errors++;
            $display("FAIL %s_route: s_tready=%b m_tvalid=%b required only source %0d enabled",
                     name, s_axis.tready, m_axis.tvalid, d);
         end
         if (d >= 0 && m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
            exp_last = LAST_CHK ? (exp_q[0].left == 1) : src_last(d, src_cnt[d]);
            checks++;
            if (m_axis.tdata !== beat_data(d, src_cnt[d]) || m_axis.tkeep !== keep_of(d, src_cnt[d]) ||
                m_axis.tid !== id_of(d, src_cnt[d]) || m_axis.tlast !== exp_last) begin
               errors++;
               $display("FAIL %s_beat: src %0d beat %0d tid=%0d tlast=%b data_ok=%0b required tid=%0d tlast=%b",
                        name, d, src_cnt[d], m_axis.tid, m_axis.tlast,
                        m_axis.tdata === beat_data(d, src_cnt[d]), id_of(d, src_cnt[d]), exp_last);
            end
            if (src_last(d, src_cnt[d]) != (exp_q[0].left == 1)) err_last_exp |= LAST_CHK;
            if (cyc_first < 0) cyc_first = n;
            cyc_last = n;
            cyc_n++;
            exp_q[0].left--;
            if (exp_q[0].left == 0) void'(exp_q.pop_front());
         end
         for (int i = 0; i < NI; i++)
            if (s_axis.tvalid[i] === 1'b1 && s_axis.tready[i] === 1'b1) src_cnt[i]++;
         if (sends_done && exp_q.size() == 0) idle++;
         n++;
      end
      for (int i = 0; i < NI; i++) s_axis.tvalid[i] = 1'b0;
      checks++;
      if (exp_q.size() != 0 || !sends_done) begin
         errors++;
         $display("FAIL %s_timeout: %0d transfers outstanding after %0d cycles, required 0", name, exp_q.size(), n);
      end
   endtask

   task automatic test_reset();
      mux.valid = 1'b0;
      mux.data  = '0;
      m_axis.tready = 1'b1;
      drive_sources(100);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      #1;
      checks++;
      if (m_axis.tvalid !== 1'b0 || s_axis.tready !== '0) begin
         errors++;
         $display("FAIL reset_gate: m_tvalid=%b s_tready=%b required 0", m_axis.tvalid, s_axis.tready);
      end
      checks++;
      if (cmd_used !== 0 || err_dest !== 1'b0 || err_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: cmd_used=%0d err_dest=%b err_last=%b required 0 0 0", cmd_used, err_dest, err_last);
      end
      areset = 1'b0;
      @(negedge aclk);
      #1;
      checks++;
      if (mux.ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: ready=%b required 1", mux.ready);
      end
   endtask

   task automatic test_single();
      send_cmd(2, 256);
      run_traffic("single", 100, 100, 100, 3);
      checks++;
      if (cyc_n != 4 || cyc_first != 1) begin
         errors++;
         $display("FAIL single_latency: beats=%0d first_cycle=%0d required 4 and 1", cyc_n, cyc_first);
      end
   endtask

   task automatic test_back_to_back();
      send_cmd(1, 100);
      send_cmd(3, 64);
      run_traffic("b2b", 100, 100, 100, 3);
      checks++;
      if (cyc_n != 3 || cyc_last - cyc_first != 2) begin
         errors++;
         $display("FAIL b2b_bubble: beats=%0d span=%0d required 3 and 2", cyc_n, cyc_last - cyc_first);
      end
   endtask

   task automatic test_full();
      for (int k = 0; k < 5; k++) send_cmd(0, 64);
      @(negedge aclk);
      #1;
      checks++;
      if (mux.ready !== 1'b0 || cmd_used !== 4) begin
         errors++;
         $display("FAIL full_stall: ready=%b cmd_used=%0d required 0 and 4", mux.ready, cmd_used);
      end
      sends_done = 1'b0;
      fork
         begin send_cmd(1, 64); sends_done = 1'b1; end
         run_traffic("full", 100, 100, 300, 3);
      join
      checks++;
      if (cmd_used !== 0 || mux.ready !== 1'b1) begin
         errors++;
         $display("FAIL full_resume: cmd_used=%0d ready=%b required 0 and 1", cmd_used, mux.ready);
      end
   endtask

   task automatic test_bad_dest();
      send_cmd(5, 64);
      send_cmd(0, 64);
      run_traffic("bad_dest", 100, 100, 100, 4);
      checks++;
      if (err_dest !== err_dest_exp || cyc_n != 1) begin
         errors++;
         $display("FAIL bad_dest: err_dest=%b beats=%0d required %b and 1", err_dest, cyc_n, err_dest_exp);
      end
   endtask

   task automatic test_zero_len();
      send_cmd(0, 0);
      send_cmd(1, 64);
      run_traffic("zero_len", 35, 100, 200, 4);
      checks++;
      if (cyc_n != 1 || cmd_used !== 0) begin
         errors++;
         $display("FAIL zero_len: beats=%0d cmd_used=%0d required 1 and 0", cyc_n, cmd_used);
      end
   endtask

   task automatic test_random();
      sends_done = 1'b0;
      fork
         begin
            for (int c = 0; c < 30; c++) begin
               int dd = $urandom_range(5);
               int ll = ($urandom_range(3) == 0) ? 0 : $urandom_range(300, 1);
               send_cmd(dd, ll);
               repeat ($urandom_range(2)) @(negedge aclk);
            end
            sends_done = 1'b1;
         end
         run_traffic("random", 70, 70, 5000, 8);
      join
      checks++;
      if (err_dest !== err_dest_exp || err_last !== err_last_exp || cmd_used !== 0) begin
         errors++;
         $display("FAIL random_flags: err_dest=%b err_last=%b cmd_used=%0d required %b %b 0",
                  err_dest, err_last, cmd_used, err_dest_exp, err_last_exp);
      end
   endtask

   task automatic test_reset_mid();
      m_axis.tready = 1'b1;
      drive_sources(100);
      send_cmd(2, 256);
      repeat (3) @(negedge aclk);
      #1 areset = 1'b1;
      #1;
      checks++;
      if (m_axis.tvalid !== 1'b0 || s_axis.tready !== '0) begin
         errors++;
         $display("FAIL reset_mid_gate: m_tvalid=%b s_tready=%b required 0", m_axis.tvalid, s_axis.tready);
      end
      @(negedge aclk);
      #1;
      checks++;
      if (cmd_used !== 0 || err_dest !== 1'b0 || err_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_state: cmd_used=%0d err_dest=%b err_last=%b required 0 0 0", cmd_used, err_dest, err_last);
      end
      areset = 1'b0;
      exp_q.delete();
      err_dest_exp = 1'b0;
      err_last_exp = 1'b0;
      for (int i = 0; i < NI; i++) s_axis.tvalid[i] = 1'b0;
      send_cmd(1, 64);
      run_traffic("post_reset", 100, 100, 100, 3);
      checks++;
      if (cyc_n != 1) begin
         errors++;
         $display("FAIL post_reset: beats=%0d required 1", cyc_n);
      end
   endtask

   task automatic test_tlast();
      last_base = src_cnt[3];
      last_mark = 1;
      send_cmd(3, 256);
      run_traffic("tlast", 100, 100, 100, 3);
      last_mark = -1;
      checks++;
      if (cyc_n != 4 || err_last !== err_last_exp || err_last !== LAST_CHK) begin
         errors++;
         $display("FAIL tlast_err: beats=%0d err_last=%b required 4 and %b", cyc_n, err_last, LAST_CHK);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_bad_dest();
      test_zero_len();
      test_random();
      test_reset_mid();
      test_tlast();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
